// File: rtl/core_bus_arbiter.sv
// Merges an instruction read master and a data read/write master onto one memory slave port.
// Optional starvation override for the instruction side: define CORE_BUS_ARB_STARVE_EN.
module core_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ins_rd_req,
  input  logic [31:0] i_ins_addr,
  output logic        o_ins_rd_gnt,
  output logic [31:0] o_ins_rdata,
  input  logic        i_dat_rd_req,
  input  logic        i_dat_wr_req,
  input  logic [31:0] i_dat_addr,
  input  logic [3:0]  i_dat_wr_be,
  input  logic [31:0] i_dat_wdata,
  output logic        o_dat_rd_gnt,
  output logic        o_dat_wr_gnt,
  output logic [31:0] o_dat_rdata,
  output logic        o_mem_rd_req,
  output logic        o_mem_wr_req,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wr_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rd_gnt,
  input  logic        i_mem_wr_gnt,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_INS, OWN_DAT} owner_e;

  owner_e      rd_owner_q, rd_owner_d;
  logic [31:0] ins_hold_q, ins_hold_d;
  logic [31:0] dat_hold_q, dat_hold_d;
  logic        dat_req;
  logic        force_ins;
  logic        ins_wins;
  logic        dat_wins;

  assign dat_req = i_dat_rd_req | i_dat_wr_req;

`ifdef CORE_BUS_ARB_STARVE_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_ins = (starve_cnt_q >= 4'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = 4'd0;
    if (i_ins_rd_req && !o_ins_rd_gnt)
      starve_cnt_d = (starve_cnt_q == 4'd15) ? 4'd15 : starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign force_ins = 1'b0;
`endif

  assign ins_wins = i_ins_rd_req & (~dat_req | force_ins);
  assign dat_wins = dat_req & ~ins_wins;

  always_comb begin
    o_mem_rd_req = 1'b0;
    o_mem_wr_req = 1'b0;
    o_mem_addr   = 32'h0;
    o_mem_wr_be  = 4'h0;
    o_mem_wdata  = 32'h0;
    if (ins_wins) begin
      o_mem_rd_req = 1'b1;
      o_mem_addr   = i_ins_addr;
    end else if (dat_wins) begin
      // A simultaneous data read is dropped in favour of the write.
      o_mem_rd_req = ~i_dat_wr_req;
      o_mem_wr_req = i_dat_wr_req;
      o_mem_addr   = i_dat_addr;
      o_mem_wr_be  = i_dat_wr_req ? i_dat_wr_be : 4'h0;
      o_mem_wdata  = i_dat_wr_req ? i_dat_wdata : 32'h0;
    end
  end

  assign o_ins_rd_gnt = ins_wins & i_mem_rd_gnt;
  assign o_dat_rd_gnt = dat_wins & ~i_dat_wr_req & i_mem_rd_gnt;
  assign o_dat_wr_gnt = dat_wins & i_dat_wr_req & i_mem_wr_gnt;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (o_ins_rd_gnt)      rd_owner_d = OWN_INS;
    else if (o_dat_rd_gnt) rd_owner_d = OWN_DAT;
  end

  // Returning data is steered by who was granted last cycle, then latched per side.
  always_comb begin
    ins_hold_d  = ins_hold_q;
    dat_hold_d  = dat_hold_q;
    o_ins_rdata = ins_hold_q;
    o_dat_rdata = dat_hold_q;
    if (rd_owner_q == OWN_INS) begin
      ins_hold_d  = i_mem_rdata;
      o_ins_rdata = i_mem_rdata;
    end
    if (rd_owner_q == OWN_DAT) begin
      dat_hold_d  = i_mem_rdata;
      o_dat_rdata = i_mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner_q <= OWN_NONE;
      ins_hold_q <= 32'h0;
      dat_hold_q <= 32'h0;
    end else begin
      rd_owner_q <= rd_owner_d;
      ins_hold_q <= ins_hold_d;
      dat_hold_q <= dat_hold_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: routing, write priority, read return steering, reset, starvation.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ins_rd_req;
  logic [31:0] i_ins_addr;
  logic        o_ins_rd_gnt;
  logic [31:0] o_ins_rdata;
  logic        i_dat_rd_req;
  logic        i_dat_wr_req;
  logic [31:0] i_dat_addr;
  logic [3:0]  i_dat_wr_be;
  logic [31:0] i_dat_wdata;
  logic        o_dat_rd_gnt;
  logic        o_dat_wr_gnt;
  logic [31:0] o_dat_rdata;
  logic        o_mem_rd_req;
  logic        o_mem_wr_req;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wr_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rd_gnt;
  logic        i_mem_wr_gnt;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ins_rd_req(i_ins_rd_req), .i_ins_addr(i_ins_addr),
    .o_ins_rd_gnt(o_ins_rd_gnt), .o_ins_rdata(o_ins_rdata),
    .i_dat_rd_req(i_dat_rd_req), .i_dat_wr_req(i_dat_wr_req),
    .i_dat_addr(i_dat_addr), .i_dat_wr_be(i_dat_wr_be), .i_dat_wdata(i_dat_wdata),
    .o_dat_rd_gnt(o_dat_rd_gnt), .o_dat_wr_gnt(o_dat_wr_gnt), .o_dat_rdata(o_dat_rdata),
    .o_mem_rd_req(o_mem_rd_req), .o_mem_wr_req(o_mem_wr_req), .o_mem_addr(o_mem_addr),
    .o_mem_wr_be(o_mem_wr_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rd_gnt(i_mem_rd_gnt), .i_mem_wr_gnt(i_mem_wr_gnt), .i_mem_rdata(i_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Apply one cycle of stimulus just after the falling edge; outputs settle 1ns later.
  task automatic drv(input logic ins_req, input logic [31:0] ins_addr,
                     input logic drd, input logic dwr, input logic [31:0] daddr,
                     input logic [3:0] be, input logic [31:0] wdata,
                     input logic [31:0] mrdata);
    @(negedge clk);
    i_ins_rd_req = ins_req;
    i_ins_addr   = ins_addr;
    i_dat_rd_req = drd;
    i_dat_wr_req = dwr;
    i_dat_addr   = daddr;
    i_dat_wr_be  = be;
    i_dat_wdata  = wdata;
    i_mem_rdata  = mrdata;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_mem_rd_gnt = 1'b1;
    i_mem_wr_gnt = 1'b1;
    i_ins_rd_req = 1'b0; i_ins_addr = 32'h0;
    i_dat_rd_req = 1'b0; i_dat_wr_req = 1'b0; i_dat_addr = 32'h0;
    i_dat_wr_be = 4'h0; i_dat_wdata = 32'h0; i_mem_rdata = 32'h0;

    // Reset: grants still follow the slave combinationally
    drv(1, 32'h8, 0, 0, 0, 4'h0, 0, 32'hFFFF_FFFF);
    check("rst_ins_gnt", 32'(o_ins_rd_gnt), 32'h1);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'hFFFF_FFFF);
    check("rst_ins_rdata", o_ins_rdata, 32'h0);
    check("rst_dat_rdata", o_dat_rdata, 32'h0);
    check("idle_mem_rd_req", 32'(o_mem_rd_req), 32'h0);
    check("idle_mem_addr", o_mem_addr, 32'h0);
    rst_n = 1'b1;

    // Single instruction read
    drv(1, 32'h100, 0, 0, 0, 4'h0, 0, 32'h0);
    check("ins_rd_gnt", 32'(o_ins_rd_gnt), 32'h1);
    check("ins_mem_addr", o_mem_addr, 32'h100);
    check("ins_mem_wr_req", 32'(o_mem_wr_req), 32'h0);
    check("ins_mem_be", 32'(o_mem_wr_be), 32'h0);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'hDEAD_BEEF);
    check("ins_rdata_n1", o_ins_rdata, 32'hDEAD_BEEF);
    check("dat_rdata_untouched", o_dat_rdata, 32'h0);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'h0BAD_F00D);
    check("ins_rdata_held", o_ins_rdata, 32'hDEAD_BEEF);

    // Contention: data write wins, instruction granted next cycle
    drv(1, 32'h200, 0, 1, 32'h400, 4'hF, 32'h1234_5678, 32'h0);
    check("wr_mem_wr_req", 32'(o_mem_wr_req), 32'h1);
    check("wr_mem_rd_req", 32'(o_mem_rd_req), 32'h0);
    check("wr_mem_addr", o_mem_addr, 32'h400);
    check("wr_mem_wdata", o_mem_wdata, 32'h1234_5678);
    check("wr_mem_be", 32'(o_mem_wr_be), 32'hF);
    check("wr_dat_gnt", 32'(o_dat_wr_gnt), 32'h1);
    check("wr_ins_gnt_lost", 32'(o_ins_rd_gnt), 32'h0);
    drv(1, 32'h200, 0, 0, 0, 4'h0, 0, 32'h9999_9999);
    check("ins_after_wr_gnt", 32'(o_ins_rd_gnt), 32'h1);
    check("ins_after_wr_addr", o_mem_addr, 32'h200);
    check("wr_no_dat_hold", o_dat_rdata, 32'h0);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'h1111_2222);
    check("ins_after_wr_rdata", o_ins_rdata, 32'h1111_2222);

    // Alternating read grants
    drv(0, 0, 1, 0, 32'h10, 4'h0, 0, 32'h0);
    check("alt_dat_gnt", 32'(o_dat_rd_gnt), 32'h1);
    check("alt_dat_addr", o_mem_addr, 32'h10);
    drv(1, 32'h20, 0, 0, 0, 4'h0, 0, 32'hAAAA_0000);
    check("alt_dat_rdata", o_dat_rdata, 32'hAAAA_0000);
    check("alt_ins_not_cross", o_ins_rdata, 32'h1111_2222);
    check("alt_ins_gnt", 32'(o_ins_rd_gnt), 32'h1);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'h5555_FFFF);
    check("alt_ins_rdata", o_ins_rdata, 32'h5555_FFFF);
    check("alt_dat_not_cross", o_dat_rdata, 32'hAAAA_0000);

    // Read and write together: only the write goes out
    drv(0, 0, 1, 1, 32'h44, 4'h3, 32'hCAFE_0001, 32'h0);
    check("rw_mem_wr_req", 32'(o_mem_wr_req), 32'h1);
    check("rw_mem_rd_req", 32'(o_mem_rd_req), 32'h0);
    check("rw_dat_rd_gnt", 32'(o_dat_rd_gnt), 32'h0);
    check("rw_dat_wr_gnt", 32'(o_dat_wr_gnt), 32'h1);
    i_mem_wr_gnt = 1'b0;
    #1;
    check("rw_slave_busy_gnt", 32'(o_dat_wr_gnt), 32'h0);
    i_mem_wr_gnt = 1'b1;

    // Reset while a data read return is pending
    drv(0, 0, 1, 0, 32'h30, 4'h0, 0, 32'h0);
    check("pend_dat_gnt", 32'(o_dat_rd_gnt), 32'h1);
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'h7777_7777);
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 4'h0, 0, 32'h7777_7777);
    rst_n = 1'b1;
    check("pend_dat_discard", o_dat_rdata, 32'h0);
    check("pend_ins_cleared", o_ins_rdata, 32'h0);

    // Continuous contention
    for (int i = 0; i < 6; i++) begin
      logic exp_ins;
`ifdef CORE_BUS_ARB_STARVE_EN
      exp_ins = (i == 4);
`else
      exp_ins = 1'b0;
`endif
      drv(1, 32'h300, 1, 0, 32'h50, 4'h0, 0, 32'h0);
      check($sformatf("starve_ins_gnt_%0d", i), 32'(o_ins_rd_gnt), 32'(exp_ins));
      check($sformatf("starve_dat_gnt_%0d", i), 32'(o_dat_rd_gnt), 32'(!exp_ins));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
